// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard/flush controller.
// Holds the address width, the stall masks driven for each stall source,
// and the controller state codes.
package pipe_ctrl_pkg;

  localparam int ADDR_LEN = 32;
  typedef logic [ADDR_LEN-1:0] addr_t;
  localparam addr_t ZERO_WORD = '0;

  // Stall masks: bit0=PC, bit1=IF/ID, bit2=ID/EX, bit3=EX/MEM, bit4=MEM/WB.
  // A stall freezes its own stage and every stage upstream of it.
  localparam logic [4:0] STALL_NONE = 5'b00000;
  localparam logic [4:0] STALL_IF   = 5'b00001;
  localparam logic [4:0] STALL_ID   = 5'b00011;
  localparam logic [4:0] STALL_MEM  = 5'b01111;

  // Controller states
  localparam logic [0:0] S_RUN     = 1'b0;
  localparam logic [0:0] S_WAIT_IF = 1'b1;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-control bus between the pipeline stages and pipe_ctrl.
//   master : pipeline side -- drives stall requests and branch redirects,
//            receives stall/clear/redirect controls.
//   slave  : controller side (pipe_ctrl).
// Optional macro PIPE_CTRL_PERF_EN adds the perf_stall_cycles and
// perf_flushes counters to the bus.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic       if_stall_req;
  logic       id_stall_req;
  logic       mem_stall_req;
  logic       ex_br_req;
  addr_t      ex_br_target;
  logic [4:0] stall;
  logic       ifid_clear;
  logic       idex_clear;
  logic       pc_redirect;
  addr_t      pc_target;
  logic       stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;
`endif

  modport master (
    output if_stall_req, id_stall_req, mem_stall_req, ex_br_req, ex_br_target,
    input  stall, ifid_clear, idex_clear, pc_redirect, pc_target, stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    , input perf_stall_cycles, perf_flushes
`endif
  );

  modport slave (
    input  if_stall_req, id_stall_req, mem_stall_req, ex_br_req, ex_br_target,
    output stall, ifid_clear, idex_clear, pc_redirect, pc_target, stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    , output perf_stall_cycles, perf_flushes
`endif
  );

endinterface

// File: rtl/pipe_ctrl.sv
// Central hazard/flush controller for the 5-stage pipeline.
// Merges IF/ID/MEM stall requests and EX branch redirects into stall[4:0],
// the IF/ID and ID/EX bubble clears, and the PC redirect. A redirect raised
// while a fetch is still in flight is parked in WAIT_IF and fired once the
// fetch completes. A watchdog flags a stall that lasts STALL_TIMEOUT cycles.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous reset, active high; forces every output to 0
//   bus  - pipe_ctrl_if.slave (requests in; stall/clears/redirect/timeout out)
// Parameters: STALL_TIMEOUT (watchdog limit), TMO_W (counter width).
// Optional macro PIPE_CTRL_PERF_EN adds perf_stall_cycles / perf_flushes.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1024,
  parameter int TMO_W         = 11
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  logic [0:0]       state, nxt_state;
  addr_t            pend_target;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_flag;

  logic [4:0] stall_c;
  logic       ifid_c, idex_c, redir_c, latch_c;
  addr_t      tgt_c;

  always_comb begin
    stall_c   = STALL_NONE;
    ifid_c    = 1'b0;
    idex_c    = 1'b0;
    redir_c   = 1'b0;
    tgt_c     = ZERO_WORD;
    latch_c   = 1'b0;
    nxt_state = state;

    if (bus.mem_stall_req) begin
      stall_c = STALL_MEM;
    end else if (bus.id_stall_req) begin
      stall_c = STALL_ID;
      idex_c  = 1'b1;
    end else if (bus.if_stall_req) begin
      stall_c = STALL_IF;
      ifid_c  = 1'b1;
    end

    case (state)
      S_RUN: begin
        // EX is frozen while EX/MEM holds; the branch is re-presented later.
        if (bus.ex_br_req && !stall_c[3]) begin
          ifid_c = 1'b1;
          idex_c = 1'b1;
          if (!bus.if_stall_req) begin
            redir_c = 1'b1;
            tgt_c   = bus.ex_br_target;
          end else begin
            latch_c   = 1'b1;
            nxt_state = S_WAIT_IF;
          end
        end
      end
      default: begin
        // Whatever the in-flight fetch returns is wrong-path; drop it.
        ifid_c = 1'b1;
        if (!bus.if_stall_req) begin
          redir_c   = 1'b1;
          tgt_c     = pend_target;
          nxt_state = S_RUN;
        end
      end
    endcase

    if (rst) begin
      stall_c = STALL_NONE;
      ifid_c  = 1'b0;
      idex_c  = 1'b0;
      redir_c = 1'b0;
      tgt_c   = ZERO_WORD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      pend_target <= ZERO_WORD;
      tmo_cnt     <= '0;
      tmo_flag    <= 1'b0;
    end else begin
      state <= nxt_state;
      if (latch_c) pend_target <= bus.ex_br_target;
      if (stall_c != STALL_NONE) begin
        if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
        if (tmo_cnt == TMO_W'(STALL_TIMEOUT - 1)) tmo_flag <= 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  assign bus.stall         = stall_c;
  assign bus.ifid_clear    = ifid_c;
  assign bus.idex_clear    = idex_c;
  assign bus.pc_redirect   = redir_c;
  assign bus.pc_target     = tgt_c;
  assign bus.stall_timeout = tmo_flag & ~rst;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_c != STALL_NONE) perf_stall_q <= perf_stall_q + 32'd1;
      if (redir_c)               perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = rst ? 32'd0 : perf_stall_q;
  assign bus.perf_flushes      = rst ? 32'd0 : perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_eval = 0;
  int   n_fail = 0;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.STALL_TIMEOUT(8), .TMO_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i_if, input logic i_id, input logic i_mem,
                       input logic i_br, input addr_t tgt);
    bus.if_stall_req  = i_if;
    bus.id_stall_req  = i_id;
    bus.mem_stall_req = i_mem;
    bus.ex_br_req     = i_br;
    bus.ex_br_target  = tgt;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] st, input logic ifc,
                         input logic idc, input logic rd, input addr_t tg);
    chk({tag, ".stall"},  32'(bus.stall),       32'(st));
    chk({tag, ".ifid"},   32'(bus.ifid_clear),  32'(ifc));
    chk({tag, ".idex"},   32'(bus.idex_clear),  32'(idc));
    chk({tag, ".redir"},  32'(bus.pc_redirect), 32'(rd));
    chk({tag, ".target"}, bus.pc_target,        tg);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick();

    // Reset forces every output low even with requests active
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h1234);
    chk_out("rst_outs", 5'b00000, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rst_tmo", 32'(bus.stall_timeout), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk_out("idle", 5'b00000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Stall priority
    tick(); drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk_out("mem_id", 5'b01111, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_out("id", 5'b00011, 1'b0, 1'b1, 1'b0, 32'h0);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("id_drop", 5'b00000, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("if", 5'b00001, 1'b1, 1'b0, 1'b0, 32'h0);

    // Immediate redirect
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1040);
    chk_out("br_now", 5'b00000, 1'b1, 1'b1, 1'b1, 32'h0000_1040);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("br_now_after", 5'b00000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Redirect parked behind an in-flight fetch
    tick(); drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0200);
    chk_out("br_wait0", 5'b00001, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1'b1, 1'b0, 1'b0, (i == 1), 32'h0000_0BAD);
      chk_out($sformatf("br_wait%0d", i + 1), 5'b00001, 1'b1, 1'b0, 1'b0, 32'h0);
    end
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("br_wait_fire", 5'b00000, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
    tick();
    chk_out("br_wait_once", 5'b00000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Branch held off by a memory stall
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0300);
    chk_out("br_mem0", 5'b01111, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("br_mem1", 5'b01111, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300);
    chk_out("br_mem_fire", 5'b00000, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("br_mem_once", 5'b00000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Watchdog: flag appears after the 8th consecutive stalled cycle
    tick(); drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 7; i++) tick();
    chk("tmo_before", 32'(bus.stall_timeout), 32'h0);
    tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("tmo_set", 32'(bus.stall_timeout), 32'h1);
    tick(); tick();
    chk("tmo_sticky", 32'(bus.stall_timeout), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("tmo_rst", 32'(bus.stall_timeout), 32'h0);

    // Short stall runs never trip the watchdog
    for (int i = 0; i < 3; i++) begin
      tick(); drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      tick(); tick(); tick(); tick();
      tick(); drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    end
    chk("tmo_short", 32'(bus.stall_timeout), 32'h0);

    // Reset while a redirect is pending discards it
    tick(); drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0400);
    chk_out("rst_wait0", 5'b00001, 1'b1, 1'b1, 1'b0, 32'h0);
    tick(); drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_out("rst_wait_drop", 5'b00000, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_out("rst_wait_drop2", 5'b00000, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit");
  end

endmodule
